// File: rtl/haraka256_round_ctrl_if.sv
// Bundles the message, digest and AES-unit signals of the Haraka-256 round sequencer.
// master = hash front-end / AES-unit side, slave = the sequencer.
interface haraka256_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [127:0] aes_in;
    logic [4:0]   aes_rc_idx;
    logic [127:0] aes_out;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready, aes_out,
        input  in_ready, out_valid, out_data, aes_in, aes_rc_idx, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, aes_out,
        output in_ready, out_valid, out_data, aes_in, aes_rc_idx, busy
    );
endinterface

// File: rtl/haraka256_round_ctrl.sv
// Haraka-256 sequencer sharing one AES round unit across two lanes; HARAKA_FEEDFWD_EN adds the input feed-forward XOR.
// Latency: 32 cycles accept-to-out_valid (5 rounds x 6 cycles + FINAL), one message per 33 cycles.
// Backpressure: digest held in DONE until out_ready; no stall inside the rounds, new accept only from IDLE.
module haraka256_round_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    haraka256_round_ctrl_if.slave        bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_MIX,
        ST_FINAL,
        ST_DONE
    } state_t;

    state_t       r_state;
    logic [127:0] r_s0;
    logic [127:0] r_s1;
    logic [2:0]   r_round;
    logic [1:0]   r_slot;
    logic         r_tag;
    logic         r_wb_vld;
    logic [255:0] r_out_data;
`ifdef HARAKA_FEEDFWD_EN
    logic [255:0] r_ff;
`endif

    logic [127:0] w_mix_s0;
    logic [127:0] w_mix_s1;
    logic [255:0] w_digest;

    // Interleave the 32-bit words of both lanes: low halves into s0, high halves into s1.
    assign w_mix_s0 = {r_s1[63:32],  r_s0[63:32],  r_s1[31:0],  r_s0[31:0]};
    assign w_mix_s1 = {r_s1[127:96], r_s0[127:96], r_s1[95:64], r_s0[95:64]};

`ifdef HARAKA_FEEDFWD_EN
    assign w_digest = {r_s1, r_s0} ^ r_ff;
`else
    assign w_digest = {r_s1, r_s0};
`endif

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = (r_state == ST_DONE);
    assign bus.busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.out_data   = r_out_data;
    assign bus.aes_in     = (r_state == ST_ISSUE) ? (r_slot[0] ? r_s1 : r_s0) : '0;
    assign bus.aes_rc_idx = (r_state == ST_ISSUE) ? ({r_round, 2'b00} + {3'b000, r_slot}) : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_s0       <= '0;
            r_s1       <= '0;
            r_round    <= '0;
            r_slot     <= '0;
            r_tag      <= 1'b0;
            r_wb_vld   <= 1'b0;
            r_out_data <= '0;
`ifdef HARAKA_FEEDFWD_EN
            r_ff       <= '0;
`endif
        end else begin
            // The AES result for an ISSUE slot lands one cycle later; the tag remembers its lane.
            r_wb_vld <= (r_state == ST_ISSUE);
            r_tag    <= (r_state == ST_ISSUE) ? r_slot[0] : 1'b0;
            if (r_wb_vld) begin
                if (r_tag) begin
                    r_s1 <= bus.aes_out;
                end else begin
                    r_s0 <= bus.aes_out;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_s0    <= bus.in_data[127:0];
                        r_s1    <= bus.in_data[255:128];
`ifdef HARAKA_FEEDFWD_EN
                        r_ff    <= bus.in_data;
`endif
                        r_round <= 3'd0;
                        r_slot  <= 2'd0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_slot <= r_slot + 2'd1;
                    if (r_slot == 2'd3) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_MIX;
                end
                ST_MIX: begin
                    r_s0 <= w_mix_s0;
                    r_s1 <= w_mix_s1;
                    if (r_round < 3'd4) begin
                        r_round <= r_round + 3'd1;
                        r_slot  <= 2'd0;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    r_out_data <= w_digest;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_haraka256_round_ctrl.sv
// Bench for haraka256_round_ctrl: a stand-in AES round unit plus a round-level Haraka model.
module tb_haraka256_round_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    haraka256_round_ctrl_if bus();

    haraka256_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in AES round: any fixed nonlinear function of (state, rc index) exercises the sequencing.
    function automatic logic [127:0] aes_f(input logic [127:0] x, input logic [4:0] idx);
        logic [63:0] p;
        logic [31:0] rc;
        p  = x[63:0] * (x[127:64] | 64'h1);
        rc = 32'h9e3779b9 * ({27'd0, idx} + 32'd1);
        return {x[114:0], x[127:115]} ^ {p, p ^ 64'h0123456789abcdef} ^ {4{rc}};
    endfunction

    logic [127:0] aes_q = '0;
    always @(posedge clk) aes_q <= aes_f(bus.aes_in, bus.aes_rc_idx);
    assign bus.aes_out = aes_q;

    function automatic logic [255:0] mix_f(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] na, nb;
        na = {b[63:32],  a[63:32],  b[31:0],  a[31:0]};
        nb = {b[127:96], a[127:96], b[95:64], a[95:64]};
        return {nb, na};
    endfunction

    // Value the AES unit should see in cycle k after accept (k=1 is the cycle after the accept edge).
    function automatic logic [127:0] sched_in(input logic [255:0] din, input int k);
        logic [127:0] a, b;
        logic [255:0] m;
        int rnd, ph;
        rnd = (k - 1) / 6;
        ph  = (k - 1) % 6;
        if (rnd > 4 || ph > 3) return '0;
        a = din[127:0];
        b = din[255:128];
        for (int r = 0; r <= rnd; r++) begin
            for (int p = 0; p < 4; p++) begin
                if (r == rnd && p == ph) return (p % 2 == 1) ? b : a;
                if (p % 2 == 0) a = aes_f(a, 5'(4 * r + p));
                else            b = aes_f(b, 5'(4 * r + p));
            end
            m = mix_f(a, b);
            a = m[127:0];
            b = m[255:128];
        end
        return '0;
    endfunction

    function automatic int exp_idx(input int k);
        int rnd, ph;
        rnd = (k - 1) / 6;
        ph  = (k - 1) % 6;
        return (rnd <= 4 && ph <= 3) ? 4 * rnd + ph : 0;
    endfunction

    function automatic logic [255:0] haraka_ref(input logic [255:0] din);
        logic [127:0] a, b;
        logic [255:0] m;
        a = din[127:0];
        b = din[255:128];
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 4; p++) begin
                if (p % 2 == 0) a = aes_f(a, 5'(4 * r + p));
                else            b = aes_f(b, 5'(4 * r + p));
            end
            m = mix_f(a, b);
            a = m[127:0];
            b = m[255:128];
        end
`ifdef HARAKA_FEEDFWD_EN
        return {b, a} ^ din;
`else
        return {b, a};
`endif
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!bus.in_ready && t < 100) begin
            tick();
            t++;
        end
        chk_i(name, int'(bus.in_ready), 1);
    endtask

    // Full message: schedule monitor, latency, backpressure hold, release pulse.
    task automatic send(input logic [255:0] din, input logic [255:0] exp, input int hold);
        wait_ready("in_ready_wait");
        bus.in_data  = din;
        bus.in_valid = 1'b1;
        tick();
        for (int k = 1; k <= 31; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = {8{$urandom}};
            chk_i($sformatf("busy_k%0d", k), int'(bus.busy), 1);
            chk_i($sformatf("early_ov_k%0d", k), int'(bus.out_valid), 0);
            chk_i($sformatf("rc_idx_k%0d", k), int'(bus.aes_rc_idx), exp_idx(k));
            chk($sformatf("aes_in_k%0d", k), {128'b0, bus.aes_in}, {128'b0, sched_in(din, k)});
            tick();
        end
        chk_i("latency_ov", int'(bus.out_valid), 1);
        chk("digest", bus.out_data, exp);
        chk_i("done_busy", int'(bus.busy), 0);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            tick();
            chk_i("hold_ov", int'(bus.out_valid), 1);
            chk_i("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_data", bus.out_data, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk_i("release_in_ready", int'(bus.in_ready), 1);
        chk_i("release_ov", int'(bus.out_valid), 0);
    endtask

    typedef struct {
        logic [255:0] din;
        logic [255:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        int t, n_acc, first_ov;
        int acc[2];

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held for two edges, then released.
        tick();
        tick();
        rst = 1'b0;
        chk_i("rst_in_ready", int'(bus.in_ready), 1);
        chk_i("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", bus.out_data, '0);
        chk_i("rst_rc_idx", int'(bus.aes_rc_idx), 0);
        chk_i("rst_busy", int'(bus.busy), 0);
        chk("rst_aes_in", {128'b0, bus.aes_in}, '0);

        for (int b = 0; b < 32; b++) d[8*b +: 8] = 8'(b);
        vecs[0].din = d;
        vecs[1].din = '0;
        vecs[2].din = '1;
        vecs[3].din = {8{32'haaaa5555}};
        for (int i = 4; i < 8; i++) vecs[i].din = {8{$urandom}} ^ {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            vecs[i].exp  = haraka_ref(vecs[i].din);
            vecs[i].hold = (i == 1) ? 10 : (i % 3);
        end

        for (int i = 0; i < 8; i++) send(vecs[i].din, vecs[i].exp, vecs[i].hold);

        // Reset while the digest is waiting in DONE.
        wait_ready("rd_ready");
        bus.in_data  = vecs[3].din;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 64) begin
            tick();
            t++;
        end
        chk_i("rd_latency", t, 31);
        chk("rd_digest", bus.out_data, vecs[3].exp);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_i("rd_out_valid", int'(bus.out_valid), 0);
        chk("rd_out_data", bus.out_data, '0);
        chk_i("rd_in_ready", int'(bus.in_ready), 1);

        // Reset at cycle 13 after accept (round 2), then an all-ones message straight away.
        bus.in_data  = vecs[4].din;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_i("mr_in_ready", int'(bus.in_ready), 1);
        chk_i("mr_busy", int'(bus.busy), 0);
        chk_i("mr_rc_idx", int'(bus.aes_rc_idx), 0);
        chk("mr_aes_in", {128'b0, bus.aes_in}, '0);
        send('1, haraka_ref('1), 0);

        // Throughput with out_ready held high and in_valid asserted.
        bus.out_ready = 1'b1;
        bus.in_data   = vecs[5].din;
        bus.in_valid  = 1'b1;
        n_acc    = 0;
        first_ov = -1;
        acc[0]   = 0;
        acc[1]   = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.out_valid && first_ov < 0) begin
                first_ov = c;
                chk("tput_digest", bus.out_data, vecs[5].exp);
            end
            if (bus.in_ready && bus.in_valid && n_acc < 2) begin
                acc[n_acc] = c;
                n_acc++;
                if (n_acc == 2) bus.in_valid = 1'b0;
            end
            tick();
        end
        chk_i("tput_accepts", n_acc, 2);
        chk_i("tput_gap", acc[1] - acc[0], 33);
        chk_i("tput_latency", first_ov - acc[0], 32);
        chk_i("tput_idle", int'(bus.in_ready), 1);
        bus.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/haraka256_round_ctrl.md
# haraka256_round_ctrl

Sequencer that time-multiplexes one external single-lane AES round unit over the two 128-bit lanes of a Haraka-256 state. It accepts a 256-bit message, runs 5 Haraka rounds (2 AES rounds per lane, then MIX), applies the feed-forward, and returns the 256-bit digest. It sits between the hash front-end and the shared AES round unit and drives the round-constant ROM index.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block idle and able to accept a message.
- `in_data`  in  256  message; `[127:0]` = lane s0, `[255:128]` = lane s1.
- `out_valid`  out  1  `out_data` valid; held until accepted.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  256  digest; same lane packing as `in_data`.
- `aes_in`  out  128  state fed to the AES round unit.
- `aes_rc_idx`  out  5  round-constant index to the RC ROM; the ROM output feeds the AES unit.
- `aes_out`  in  128  AES unit result; valid exactly 1 cycle after the matching `aes_in`.
- `busy`  out  1  high in every state except IDLE and DONE.

## Operation

- **States.**
  - IDLE → ISSUE on `in_valid && in_ready`. Latch `in_data` into lane regs s0/s1 and into the feed-forward reg. Set r=0, slot=0.
  - ISSUE: 4 cycles, `slot` 0..3, with `lane = slot[0]` and `aes round = slot[1]`.
    - `aes_in` = lane reg selected by `lane`.
    - `aes_rc_idx` = 4·r + slot.
    - A 1-bit tag registers `lane`. On the next cycle `aes_out` is written into the tagged lane reg.
    - Dependency: the slot 2 issue of lane 0 reads the value written at the end of slot 1.
    - slot 3 → DRAIN.
  - DRAIN: 1 cycle; writes back the slot 3 result (lane 1). → MIX.
  - MIX: 1 cycle. With 32-bit words w0 = `[31:0]` .. w3 = `[127:96]`:
    - s0 ← {s1.w1, s0.w1, s1.w0, s0.w0} (MSB-first)
    - s1 ← {s1.w3, s0.w3, s1.w2, s0.w2}
    - If r < 4: r++, slot=0, → ISSUE. Else → FINAL.
  - FINAL: 1 cycle; `out_data` reg ← {s1,s0} XOR feed-forward (see Configuration). → DONE.
  - DONE: `out_valid`=1. On `out_ready` → IDLE.
- **Outside ISSUE:** `aes_in` = 0 and `aes_rc_idx` = 0.
- **`in_ready`:** equals (state == IDLE). No overlap of a new accept with the DONE handshake; a new message is accepted at the earliest the cycle after `out_ready`.
- **Stalls:** `out_data` is stable while `out_valid && !out_ready`. There is no stall path inside ISSUE/DRAIN/MIX, because the AES unit has no enable.
- **`rc_idx` range:** 0..19; never 20..31.

## Timing

- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `aes_in`=0, `aes_rc_idx`=0, `busy`=0, r=slot=tag=0.
- Each round takes 6 cycles: 4 ISSUE, 1 DRAIN, 1 MIX.
- Let the accept edge be edge 0. Edges 1–30 cover the 5 rounds; edge 31 is FINAL.
- `out_valid` is first high in the cycle after edge 31, so accept-to-`out_valid` latency is 32 cycles.
- Throughput: one message per 33 cycles with `out_ready` held high.
- `rst` asserted in any state: at the next edge, all registers return to reset values. The in-flight message is discarded. An AES result arriving the cycle after reset is ignored.
- `in_valid` while not IDLE is ignored, with no side effects.

## Configuration

- `HARAKA_FEEDFWD_EN`
  - Defined: `out_data` = permuted state XOR latched input. This is the standard Haraka-256 output.
  - Undefined: `out_data` = raw permuted state {s1,s0}, i.e. the bare permutation π, used for permutation-level verification. The feed-forward register is not instantiated.
  - Cycle timing is identical in both builds.

## Test plan

- **Reset:** hold `rst` 2 cycles, then release. Require `in_ready`=1, `out_valid`=0, `out_data`=0, `aes_rc_idx`=0.
- **Golden vector:** `in_data` bytes 0x00..0x1f (byte 0 at `[7:0]`), real AES unit and RC ROM, feed-forward enabled. Require:
  - `out_data` equals the team Haraka-256 C-model result;
  - `out_valid` rises exactly 32 cycles after accept.
- **Schedule:** monitor ISSUE cycles. Require the `aes_rc_idx` sequence 0,1,2,…,19 with no repeats. Require the `aes_in` lane pattern s0,s1,s0,s1 per round, and exactly 20 issue cycles per message.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`. Require:
  - `out_data` stable throughout;
  - `in_ready`=0 throughout;
  - after one `out_ready` pulse, `in_ready`=1 on the next cycle and a second message is accepted on the cycle after that.
- **Mid-run reset:** assert `rst` at cycle 13 after accept (round 2). Require IDLE on the next cycle. A fresh message 0xFF..FF then completes with the correct C-model digest in 32 cycles.
- **Build without `HARAKA_FEEDFWD_EN`:** all-zero input. Require `out_data` equals C-model π(0) with no XOR, and the same 32-cycle latency.
